dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Sequencer and arbiter for the single-port synchronous data RAM behind the pipeline's Memory stage. It shares the RAM between the CPU data port and an external word-wide port used for debug and loading. It turns byte and halfword stores (sb/sh) into read-modify-write sequences and drives a stall request into the hazard unit while a CPU access is still in flight. It sits between the M-stage datapath and the data RAM macro.

## Interface
Parameters:
- DEPTH, 64: RAM depth in 32-bit words; power of two.
- AW, $clog2(DEPTH): RAM word-address width (derived).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- cpu_req  in  1  CPU access request; held stable until cpu_done.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and raises err.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data, right-aligned.
- cpu_rdata  out  32  aligned RAM word; sub-word extraction happens outside this block.
- cpu_done  out  1  completion strobe.
- cpu_stall  out  1  cpu_req & ~cpu_done, combinational; goes to the hazard unit.
- cpu_err  out  1  one-cycle pulse on a misaligned or illegal-size access.
- ext_req / ext_we  in  1  external request and write enable; word accesses only; addr[1:0] ignored.
- ext_addr  in  32; ext_wdata  in  32; ext_rdata  out  32; ext_done  out  1.
- ram_en, ram_we  out  1; ram_addr  out  AW; ram_wdata  out  32; ram_rdata  in  32, valid one cycle after the read enable.

## Operation
- FSM states: IDLE, RD, MERGE.
- Arbitration happens in IDLE only:
  - round-robin; last_owner flips on every grant;
  - after reset the CPU has priority;
  - if both ports request, the port that was not served last wins.
- Granted word store: ram_en = ram_we = 1 in the grant cycle; done in the same cycle; stays in IDLE.
- Granted load: ram_en = 1, ram_we = 0; go to RD. In RD, rdata = ram_rdata, done = 1, return to IDLE.
- Granted CPU sb/sh: read the word; go to MERGE. In MERGE:
  - write the merged word; done = 1; return to IDLE.
  - Merge is little-endian: lane = addr[1:0]; byte → wdata[7:0] into lane; half → wdata[15:0] into lanes {addr[1],0}.
- Misaligned access (half with addr[0] = 1, word with addr[1:0] ≠ 0) or size 11:
  - no RAM access;
  - cpu_done and cpu_err pulse in the grant cycle;
  - counts as a grant for round-robin.
- Address wrap: ram_addr = addr[AW+1:2]; upper bits are ignored.
- cpu_rdata and ext_rdata are held in registers between completions.

## Timing
- Reset values: state = IDLE, last_owner = ext (so the CPU wins first), all done/err = 0, rdata = 0, ram_en = ram_we = 0.
- Latency from grant cycle (cycle 0): word store and error done at cycle 0; load and sub-word store done at cycle 1.
- An ungranted requester waits a maximum of 2 cycles.
- A new grant is possible in the cycle after a done that was issued in RD or MERGE.
- Back-to-back word stores from one port take 1 per cycle, unless the other port is requesting; then grants alternate.
- Reset asserted mid-RMW: the FSM returns to IDLE asynchronously, ram_we drops immediately, and no partial write occurs.
- The deassertion edge is not sampled as a grant.
- A request that drops before its done is a protocol violation; behaviour is undefined and flagged by a bench assertion.

## Structure
- dmem_pkg holds:
  - SZ_B / SZ_H / SZ_W encodings;
  - state_t enum {IDLE, RD, MERGE};
  - owner_t {OWN_CPU, OWN_EXT}.
- Sub-module store_merge is combinational: (old word, wdata, size, lane) → merged word. It is reused by the future cache write path.
- Top module holds the FSM, round-robin register, muxes and rdata holding registers.

## Test plan
- RAM word 24 (addr 96) = 0xAA0BC0DD; CPU load from 96 → cpu_stall high 1 cycle, cpu_rdata = 0xAA0BC0DD at done.
- CPU sb 0x33 to 96 → RAM[24] = 0xAA0BC033 at cycle 1. Then sh 0x1234 to 98 → 0x1234C033.
- CPU and ext both request from reset → CPU granted first, ext done 1–2 cycles later. Repeated dual requests alternate.
- sh to addr 97 → cpu_err and cpu_done pulse same cycle, RAM unchanged, no ram_en.
- Reset pulsed while in MERGE of sb to 99 → RAM[24] unchanged, all outputs return to reset values.
- Ext write 30 to addr 40 then ext read → ext_rdata = 30; addr 40 + 4·DEPTH aliases to the same word.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, sequencer states
// and port ownership.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, MERGE} state_t;
  typedef enum logic {OWN_CPU, OWN_EXT} owner_t;

  // Illegal size or an address not aligned to the access size.
  function automatic logic badAccess(input logic [1:0] size, input logic [1:0] lane);
    badAccess = (size == 2'b11) ||
                (size == SZ_H && lane[0]) ||
                (size == SZ_W && lane != 2'b00);
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational little-endian store merge: inserts a byte or halfword into an
// existing word at the given byte lane; word size passes wdata through.
module store_merge
  import dmem_pkg::*;
(
  input  logic [31:0] oldWord,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  output logic [31:0] merged
);

  always_comb begin
    merged = oldWord;
    case (size)
      SZ_B:    merged[{lane, 3'b000} +: 8] = wdata[7:0];
      SZ_H:    merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU data port and the external
// word port; sequences loads and sub-word read-modify-write stores.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_size,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_stall,
  output logic          cpu_err,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [31:0]   ext_addr,
  input  logic [31:0]   ext_wdata,
  output logic [31:0]   ext_rdata,
  output logic          ext_done,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output state_t        dbgState
);

  // Handshake: a requester raises req with stable command fields and holds them
  // until it sees done for one cycle; it may drop req or issue the next command
  // in the cycle after done. There is no separate ready; done is the acceptance.
  state_t        state, nextState;
  owner_t        lastOwner, nextLastOwner, owner, nextOwner;
  logic [31:0]   cpuRdataQ, extRdataQ, mergedWord;
  logic [AW-1:0] cpuWord, extWord;
  logic          cpuWins, extWins, cpuBad;
  logic          unusedAddrBits;

  assign cpuWord        = cpu_addr[AW+1:2];
  assign extWord        = ext_addr[AW+1:2];
  assign unusedAddrBits = ^{cpu_addr[31:AW+2], ext_addr[31:AW+2], ext_addr[1:0]};
  assign cpuBad         = badAccess(cpu_size, cpu_addr[1:0]);
  assign cpuWins        = cpu_req && (!ext_req || lastOwner == OWN_EXT);
  assign extWins        = ext_req && !cpuWins;
  assign dbgState       = state;
  assign cpu_stall      = cpu_req & ~cpu_done;

  store_merge u_merge (
    .oldWord (ram_rdata),
    .wdata   (cpu_wdata),
    .size    (cpu_size),
    .lane    (cpu_addr[1:0]),
    .merged  (mergedWord)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lastOwner <= OWN_EXT;
      owner     <= OWN_CPU;
      cpuRdataQ <= '0;
      extRdataQ <= '0;
    end else begin
      state     <= nextState;
      lastOwner <= nextLastOwner;
      owner     <= nextOwner;
      if (state == RD && owner == OWN_CPU) cpuRdataQ <= ram_rdata;
      if (state == RD && owner == OWN_EXT) extRdataQ <= ram_rdata;
    end
  end

  // Outputs are gated by reset so an RMW write cannot leak while reset is low.
  always_comb begin
    nextState     = state;
    nextOwner     = owner;
    nextLastOwner = lastOwner;
    ram_en        = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = cpuWord;
    ram_wdata     = cpu_wdata;
    cpu_done      = 1'b0;
    cpu_err       = 1'b0;
    ext_done      = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (cpuWins) begin
            nextLastOwner = OWN_CPU;
            nextOwner     = OWN_CPU;
            if (cpuBad) begin
              cpu_done = 1'b1;
              cpu_err  = 1'b1;
            end else begin
              ram_en = 1'b1;
              if (cpu_we && cpu_size == SZ_W) begin
                ram_we   = 1'b1;
                cpu_done = 1'b1;
              end else if (cpu_we) begin
                nextState = MERGE;
              end else begin
                nextState = RD;
              end
            end
          end else if (extWins) begin
            nextLastOwner = OWN_EXT;
            nextOwner     = OWN_EXT;
            ram_en        = 1'b1;
            ram_addr      = extWord;
            ram_wdata     = ext_wdata;
            if (ext_we) begin
              ram_we   = 1'b1;
              ext_done = 1'b1;
            end else begin
              nextState = RD;
            end
          end
        end
        RD: begin
          if (owner == OWN_CPU) cpu_done = 1'b1;
          else                  ext_done = 1'b1;
          nextState = IDLE;
        end
        MERGE: begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_wdata = mergedWord;
          cpu_done  = 1'b1;
          nextState = IDLE;
        end
        default: nextState = IDLE;
      endcase
    end
  end

  // Read data is visible in the done cycle and held afterwards.
  assign cpu_rdata = (state == RD && owner == OWN_CPU) ? ram_rdata : cpuRdataQ;
  assign ext_rdata = (state == RD && owner == OWN_EXT) ? ram_rdata : extRdataQ;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural RAM and an
// expected-read-data queue.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_done, cpu_stall, cpu_err;
  logic [1:0]    cpu_size;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          ext_req, ext_we, ext_done;
  logic [31:0]   ext_addr, ext_wdata, ext_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;
  state_t        dbgState;

  logic [31:0] mem [DEPTH];
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  dmem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_done(ext_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .dbgState(dbgState)
  );

  // ---------------- clock / reset / RAM model ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Requesters must hold req until done.
  logic cpuPend = 1'b0;
  logic extPend = 1'b0;
  always @(posedge clk) begin
    cpuPend <= reset & cpu_req & ~cpu_done;
    extPend <= reset & ext_req & ~ext_done;
  end
  always @(negedge clk) begin
    if (reset) begin
      assert (!(cpuPend && !cpu_req)) else begin
        errors++; $error("FAIL protocol: cpu_req dropped before done");
      end
      assert (!(extPend && !ext_req)) else begin
        errors++; $error("FAIL protocol: ext_req dropped before done");
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic cpu_op(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output int doneCyc,
                        output logic err, output logic stall0, output logic sawEn,
                        output logic [31:0] rd);
    cpu_we = we; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    lat = -1; doneCyc = -1; err = 1'b0; stall0 = 1'b0; sawEn = 1'b0; rd = '0;
    for (int c = 0; c < 20 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 0) stall0 = cpu_stall;
      if (ram_en) sawEn = 1'b1;
      if (cpu_done) begin
        lat = c; doneCyc = cyc; err = cpu_err; rd = cpu_rdata;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic ext_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output int doneCyc, output logic [31:0] rd);
    ext_we = we; ext_addr = addr; ext_wdata = wdata; ext_req = 1'b1;
    lat = -1; doneCyc = -1; rd = '0;
    for (int c = 0; c < 20 && lat < 0; c++) begin
      @(negedge clk);
      if (ext_done) begin
        lat = c; doneCyc = cyc; rd = ext_rdata;
      end
    end
    @(posedge clk); #1;
    ext_req = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  int lat, dc, l2, cpuC0, cpuC1, extC0, extC1;
  logic er, st, en;
  logic [31:0] rd, rd2;

  initial begin
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_size = SZ_W; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
    @(negedge clk); @(negedge clk);
    check("rst_cpu_done", cpu_done, 0);
    check("rst_ext_done", ext_done, 0);
    check("rst_cpu_err", cpu_err, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_ext_rdata", ext_rdata, 0);
    check("rst_ram_en_we", {ram_en, ram_we}, 0);
    check("rst_state", dbgState, IDLE);
    @(posedge clk); #1 reset = 1'b1;

    // Seed word 24 through the external port.
    ext_op(1'b1, 32'd96, 32'hAA0BC0DD, lat, dc, rd);
    check("ext_wr_lat", lat, 0);
    check("seed_mem24", mem[24], 32'hAA0BC0DD);

    // CPU word load.
    exp_q.push_back(32'hAA0BC0DD);
    cpu_op(1'b0, SZ_W, 32'd96, 32'h0, lat, dc, er, st, en, rd);
    check("cpu_ld_lat", lat, 1);
    check("cpu_ld_stall", st, 1);
    check("cpu_ld_rdata", rd, exp_q.pop_front());
    check("cpu_ld_err", er, 0);
    @(posedge clk); #1;
    check("cpu_rdata_hold", cpu_rdata, 32'hAA0BC0DD);
    check("cpu_stall_idle", cpu_stall, 0);

    // Sub-word stores.
    cpu_op(1'b1, SZ_B, 32'd96, 32'hFFFFFF33, lat, dc, er, st, en, rd);
    check("sb_lat", lat, 1);
    check("sb_mem24", mem[24], 32'hAA0BC033);
    cpu_op(1'b1, SZ_H, 32'd98, 32'hFFFF1234, lat, dc, er, st, en, rd);
    check("sh_lat", lat, 1);
    check("sh_mem24", mem[24], 32'h1234C033);

    // Misaligned and illegal accesses.
    cpu_op(1'b1, SZ_H, 32'd97, 32'h5555, lat, dc, er, st, en, rd);
    check("sh97_lat", lat, 0);
    check("sh97_err", er, 1);
    check("sh97_no_ram", en, 0);
    check("sh97_mem24", mem[24], 32'h1234C033);
    cpu_op(1'b0, 2'b11, 32'd96, 32'h0, lat, dc, er, st, en, rd);
    check("size11_err", er, 1);
    check("size11_no_ram", en, 0);
    cpu_op(1'b1, SZ_W, 32'd98, 32'h0, lat, dc, er, st, en, rd);
    check("word98_err", er, 1);
    check("word98_mem24", mem[24], 32'h1234C033);
    @(negedge clk);
    check("err_is_pulse", cpu_err, 0);
    @(posedge clk); #1;

    // CPU word store.
    cpu_op(1'b1, SZ_W, 32'd100, 32'hDEADBEEF, lat, dc, er, st, en, rd);
    check("sw_lat", lat, 0);
    check("sw_mem25", mem[25], 32'hDEADBEEF);

    // External write/read and address aliasing.
    ext_op(1'b1, 32'd40, 32'd30, lat, dc, rd);
    check("ext_wr40_lat", lat, 0);
    exp_q.push_back(32'd30);
    ext_op(1'b0, 32'd40, 32'h0, lat, dc, rd);
    check("ext_rd40_lat", lat, 1);
    check("ext_rd40_data", rd, exp_q.pop_front());
    exp_q.push_back(32'd30);
    ext_op(1'b0, 32'd40 + 4 * DEPTH, 32'h0, lat, dc, rd);
    check("ext_rd_alias", rd, exp_q.pop_front());
    check("ext_rdata_hold", ext_rdata, 32'd30);

    // Reset in the middle of an sb to 99.
    cpu_we = 1'b1; cpu_size = SZ_B; cpu_addr = 32'd99; cpu_wdata = 32'h77; cpu_req = 1'b1;
    @(negedge clk);
    check("rmw_read_phase", {ram_en, ram_we}, 2'b10);
    @(posedge clk); #1;
    check("rmw_in_merge", dbgState, MERGE);
    check("rmw_merge_we", ram_we, 1);
    reset = 1'b0; #1;
    check("rmw_rst_state", dbgState, IDLE);
    check("rmw_rst_ram", {ram_en, ram_we}, 0);
    check("rmw_rst_done", {cpu_done, cpu_err, ext_done}, 0);
    check("rmw_rst_cpu_rdata", cpu_rdata, 0);
    check("rmw_rst_ext_rdata", ext_rdata, 0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    check("rmw_rst_mem24", mem[24], 32'h1234C033);
    @(posedge clk); #1 reset = 1'b1;

    // Dual requesters from reset: CPU first, then strict alternation.
    fork
      begin
        cpu_op(1'b1, SZ_W, 32'd104, 32'h11111111, lat, cpuC0, er, st, en, rd);
        cpu_op(1'b1, SZ_W, 32'd108, 32'h22222222, lat, cpuC1, er, st, en, rd);
      end
      begin
        ext_op(1'b1, 32'd112, 32'h33333333, l2, extC0, rd2);
        ext_op(1'b1, 32'd116, 32'h44444444, l2, extC1, rd2);
      end
    join
    check("dual_cpu_first", (cpuC0 >= 0 && extC0 - cpuC0 == 1), 1);
    check("dual_alt_cpu", cpuC1 - extC0, 1);
    check("dual_alt_ext", extC1 - cpuC1, 1);
    check("dual_mem26", mem[26], 32'h11111111);
    check("dual_mem27", mem[27], 32'h22222222);
    check("dual_mem28", mem[28], 32'h33333333);
    check("dual_mem29", mem[29], 32'h44444444);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
